// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial adder/subtractor built around one full-adder
// cell (two half adders plus an OR for the carry). It processes one bit per
// clock, LSB first, and uses a START/BUSY/DONE handshake. The result holds
// until the next accepted START.
module serial_add_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SnA,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  CO,
    output logic                  V,
    output logic                  BUSY,
    output logic                  DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Counter values at which the carry into the MSB is captured, and at which
    // the last bit is processed.
    localparam logic [CNT_WIDTH-1:0] CNT_PRE_MSB = CNT_WIDTH'(DATA_WIDTH - 2);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic [DATA_WIDTH-1:0]   result;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    carry;
    logic                    carry_into_msb;

    // Full-adder cell: two half adders in series, with their carries ORed.
    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;
    logic fa_sum;
    logic fa_carry;

    assign ha1_sum   = op_a[0] ^ op_b[0];
    assign ha1_carry = op_a[0] & op_b[0];
    assign fa_sum    = ha1_sum ^ carry;
    assign ha2_carry = ha1_sum & carry;
    assign fa_carry  = ha1_carry | ha2_carry;

    // State register.
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a START request is accepted only in IDLE. RUN lasts
    // DATA_WIDTH cycles, and FIN lasts a single cycle.
    // NOTE: assigning a default first means no path can leave state_next unassigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (START) state_next = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the state register alone, so no
    // input reaches them combinationally.
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        unique case (state)
            S_RUN:   BUSY = 1'b1;
            S_FIN:   begin BUSY = 1'b1; DONE = 1'b1; end
            default: ;
        endcase
    end

    // Datapath: load the operands on START, then shift one bit per cycle.
    // Y, CO and V are written only on the final RUN edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_a           <= '0;
            op_b           <= '0;
            result         <= '0;
            cnt            <= '0;
            carry          <= 1'b0;
            carry_into_msb <= 1'b0;
            Y              <= '0;
            CO             <= 1'b0;
            V              <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        // Subtraction is A + ~B + 1.
                        op_a   <= A;
                        op_b   <= SnA ? ~B : B;
                        carry  <= SnA;
                        cnt    <= '0;
                        result <= '0;
                    end
                end
                S_RUN: begin
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= fa_carry;
                    cnt    <= cnt + CNT_WIDTH'(1);
                    result <= {fa_sum, result[DATA_WIDTH-1:1]};
                    if (cnt == CNT_PRE_MSB) begin
                        carry_into_msb <= fa_carry;
                    end
                    if (cnt == CNT_LAST) begin
                        Y  <= {fa_sum, result[DATA_WIDTH-1:1]};
                        CO <= fa_carry;
                        V  <= fa_carry ^ carry_into_msb;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
